imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle LEGv8 core fetches from.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory addresses.
- Holds the core in reset with a start PC supplied, then releases the core once the program is loaded.

Parameters:
- IMEM_DEPTH, 256, maximum number of 32-bit words the loader accepts.
- BASE_ADDR, 64'h0, byte address of word 0.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- resetl  input  1  reset, synchronous, active-high.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_waddr  output  64  word-aligned byte address.
- imem_wdata  output  32  instruction word.
- core_resetl  output  1  core reset, active-low; 0 holds the core at startpc.
- core_startpc  output  64  start PC presented to the core.
- done  output  1  load complete; core running.
- error  output  1  sticky frame error.

Behaviour:
- Frame format: 2-byte word count N (LE), then 8-byte start PC (LE), then 4*N instruction bytes (LE per word).
- A byte transfers on a posedge where in_valid && in_ready.
- Reset values: in_ready=0, imem_we=0, imem_waddr=BASE_ADDR, imem_wdata=0, core_resetl=0, core_startpc=0, done=0, error=0. All internal counters are cleared and the state is HDR_CNT.
- in_ready is a registered output:
  - 1 in HDR_CNT, HDR_PC and DATA (and CSUM when the optional feature is enabled).
  - 0 in HOLD, RUN and ERR.
  - It becomes 1 on the first cycle after reset is deasserted.
- States:
  - HDR_CNT: accept 2 bytes into N.
    - N==0 or N>IMEM_DEPTH -> ERR.
    - Otherwise -> HDR_PC.
  - HDR_PC: accept 8 bytes into core_startpc. core_startpc updates only when the 8th byte is accepted.
    - startpc[1:0]!=0 -> ERR.
    - (startpc-BASE_ADDR) >= 4*N -> ERR.
    - Otherwise -> DATA.
  - DATA: 2-bit byte index; bytes are shifted into a 32-bit word, byte 0 into bits [7:0].
    - On the 4th byte, the next cycle drives imem_we=1 with imem_wdata equal to the word and imem_waddr=BASE_ADDR+4*i (write latency 1 cycle).
    - i increments after each write.
    - After word N-1 is accepted -> HOLD (or CSUM when the optional feature is enabled).
  - HOLD: exactly one cycle with core_resetl=0 and core_startpc stable. This guarantees the core's negedge latch of startpc while the final write completes. Then -> RUN.
  - RUN: core_resetl=1, done=1. Terminal state until resetl.
  - ERR: error=1, core_resetl=0, in_ready=0. Sticky until resetl.
- Stall rules:
  - in_valid low holds all state.
  - Stalls between bytes of one word are allowed.
  - imem_we is never asserted for a partial word.
- core_resetl is 0 in every state except RUN.
- resetl asserted mid-load aborts the load: all outputs return to reset values next cycle; words already written are not erased.
- Bytes offered while in_ready=0 are ignored (not consumed).
- N==IMEM_DEPTH is legal; the last address is BASE_ADDR+4*(IMEM_DEPTH-1).
- Address arithmetic is 64-bit, modulo 2^64.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte the FSM enters CSUM and accepts 1 byte.
  - If that byte equals the XOR of all 4*N data bytes -> HOLD; otherwise -> ERR.
  - Header bytes are not included in the XOR.
- Undefined: no CSUM state and no checksum register; last data byte -> HOLD.

Decomposition:
- Package imem_loader_pkg contains:
  - state encoding (HDR_CNT, HDR_PC, DATA, CSUM, HOLD, RUN, ERR);
  - header byte counts (CNT_BYTES=2, PC_BYTES=8);
  - WORD_BYTES=4.
- Sub-module imem_byte_packer: a parameterised little-endian shift packer (width, byte count) with a full pulse. It is instantiated once, reused for N, the start PC and instruction words.

Test Plan:
- Basic load:
  - Stimulus: 01 00, 00×8, then E9 03 40 F8.
  - Response: one imem_we with waddr=0, wdata=32'hF84003E9; one HOLD cycle; core_resetl=1; done=1; core_startpc=0.
- Three words, startpc=8, in_valid toggled every other cycle:
  - Writes to addresses 0, 4 and 8 in order.
  - No imem_we during stalls.
  - core_startpc=64'h8.
- Count errors:
  - N=0 -> error=1 after the 2nd byte, in_ready=0, no writes.
  - N=IMEM_DEPTH+1 -> same response.
- PC errors:
  - startpc=64'h6 -> error=1 after the 8th PC byte.
  - startpc=4*N -> same response.
- Reset mid-load: assert resetl after 2 of 4 data bytes.
  - Next cycle: all outputs at reset values.
  - A subsequent full frame loads correctly.
- Checksum (with IMEM_LOADER_CHECKSUM_EN), data E9 03 40 F8:
  - Checksum byte 0x52 -> done=1.
  - Checksum byte 0x53 -> error=1, core_resetl stays 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_CNT,
        HDR_PC,
        DATA,
        CSUM,
        HOLD,
        RUN,
        ERR
    } state_t;

    localparam int CNT_BYTES  = 2;
    localparam int PC_BYTES   = 8;
    localparam int WORD_BYTES = 4;

    // Packer is sized for the widest field (start PC).
    localparam int PK_W  = 64;
    localparam int PK_CW = $clog2(PK_W / 8 + 1);

    function automatic logic accepts_bytes(state_t s);
        return s inside {HDR_CNT, HDR_PC, DATA, CSUM};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and core-control bundle of the loader.
interface imem_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_resetl;
    logic [63:0] core_startpc;
    logic        done;
    logic        error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata,
               core_resetl, core_startpc, done, error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata,
               core_resetl, core_startpc, done, error
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Little-endian shift packer: assembles nbytes bytes (runtime selectable, up to W/8)
// into an LSB-aligned word; full pulses combinationally on the last byte's accept.
module imem_byte_packer #(
    parameter int W  = 64,
    parameter int CW = $clog2(W / 8 + 1)
) (
    input  logic          CLK,
    input  logic          resetl,
    input  logic          en,
    input  logic [CW-1:0] nbytes,
    input  logic [7:0]    din,
    output logic [W-1:0]  word,
    output logic          full
);

    localparam int BYTES = W / 8;

    logic [W-9:0]  acc;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shifted;
    logic [CW+2:0] shamt;

    // New bytes enter at the top, so after nbytes shifts the field sits in the
    // top nbytes bytes; shamt brings it back down to bit 0.
    assign shifted = {din, acc};
    assign shamt   = {CW'(BYTES) - nbytes, 3'b000};
    assign word    = shifted >> shamt;
    assign full    = en && (cnt == nbytes - CW'(1));

    always_ff @(posedge CLK) begin
        if (resetl) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            acc <= shifted[W-1:8];
            cnt <= full ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction-memory writes, then core release.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [63:0] BASE_ADDR  = 64'h0
) (
    input  logic          CLK,
    input  logic          resetl,
    imem_loader_if.slave  bus
);

    localparam logic [31:0] DEPTH_U = 32'(IMEM_DEPTH);

    state_t state, state_nxt;

    logic             xfer;
    logic [15:0]      n_words;
    logic [15:0]      word_idx;
    logic             last_word;
    logic [63:0]      pc_off;
    logic [63:0]      span;
    logic             pk_en;
    logic             pk_full;
    logic [PK_CW-1:0] pk_nbytes;
    logic [PK_W-1:0]  pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign xfer      = bus.in_valid && bus.in_ready;
    assign last_word = (word_idx == n_words - 16'd1);
    assign pc_off    = pk_word - BASE_ADDR;
    assign span      = {46'b0, n_words, 2'b00};

    imem_byte_packer #(.W(PK_W), .CW(PK_CW)) u_packer (
        .CLK    (CLK),
        .resetl (resetl),
        .en     (pk_en),
        .nbytes (pk_nbytes),
        .din    (bus.in_data),
        .word   (pk_word),
        .full   (pk_full)
    );

    always_ff @(posedge CLK) begin
        if (resetl) state <= HDR_CNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pk_en     = 1'b0;
        pk_nbytes = PK_CW'(WORD_BYTES);
        case (state)
            HDR_CNT: begin
                pk_en     = xfer;
                pk_nbytes = PK_CW'(CNT_BYTES);
                if (pk_full)
                    state_nxt = (pk_word[15:0] == 16'd0 || {16'b0, pk_word[15:0]} > DEPTH_U)
                                ? ERR : HDR_PC;
            end
            HDR_PC: begin
                pk_en     = xfer;
                pk_nbytes = PK_CW'(PC_BYTES);
                if (pk_full)
                    state_nxt = (pk_word[1:0] != 2'b00 || pc_off >= span) ? ERR : DATA;
            end
            DATA: begin
                pk_en     = xfer;
                pk_nbytes = PK_CW'(WORD_BYTES);
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (pk_full && last_word) state_nxt = CSUM;
`else
                if (pk_full && last_word) state_nxt = HOLD;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer) state_nxt = (bus.in_data == csum) ? HOLD : ERR;
            end
`endif
            HOLD:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            ERR:     state_nxt = ERR;
            default: state_nxt = ERR;
        endcase
    end

    // Outputs are registered from the next state so in_ready, core_resetl,
    // done and error change on the same edge as the state they describe.
    always_ff @(posedge CLK) begin
        if (resetl) begin
            bus.in_ready     <= 1'b0;
            bus.imem_we      <= 1'b0;
            bus.imem_waddr   <= BASE_ADDR;
            bus.imem_wdata   <= '0;
            bus.core_resetl  <= 1'b0;
            bus.core_startpc <= '0;
            bus.done         <= 1'b0;
            bus.error        <= 1'b0;
            n_words          <= '0;
            word_idx         <= '0;
        end else begin
            bus.in_ready    <= accepts_bytes(state_nxt);
            bus.core_resetl <= (state_nxt == RUN);
            bus.done        <= (state_nxt == RUN);
            bus.error       <= (state_nxt == ERR);
            bus.imem_we     <= 1'b0;
            if (state == HDR_CNT && pk_full) n_words <= pk_word[15:0];
            if (state == HDR_PC && pk_full)  bus.core_startpc <= pk_word;
            if (state == DATA && pk_full) begin
                bus.imem_we    <= 1'b1;
                bus.imem_wdata <= pk_word[31:0];
                bus.imem_waddr <= BASE_ADDR + {46'b0, word_idx, 2'b00};
                word_idx       <= word_idx + 16'd1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Only instruction bytes contribute; header bytes are excluded.
    always_ff @(posedge CLK) begin
        if (resetl)                   csum <= '0;
        else if (state == DATA && xfer) csum <= csum ^ bus.in_data;
    end
`endif

endmodule
